// File: rtl/ro_puf_sequencer_pkg.sv
// ro_puf_sequencer_pkg: FSM state type and synchroniser depth shared by the RO PUF sequencer
package ro_puf_sequencer_pkg;
    typedef enum logic [2:0] {IDLE, SETTLE, COUNT, COMPARE, DONE} state_t;
    localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/ro_puf_sequencer_if.sv
// ro_puf_sequencer_if: host-side request/response bundle of the RO PUF sequencer
interface ro_puf_sequencer_if #(
    parameter int SEL_W     = 4,
    parameter int CNT_W     = 16,
    parameter int WIN_W     = 16,
    parameter int RESP_BITS = 8
);
    logic                 start;
    logic [SEL_W-1:0]     challenge_a;
    logic [SEL_W-1:0]     challenge_b;
    logic [WIN_W-1:0]     window_len;
    logic [CNT_W-1:0]     tie_thresh;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] response;
    logic [RESP_BITS-1:0] unstable;
    logic [CNT_W-1:0]     last_cnt_a;
    logic [CNT_W-1:0]     last_cnt_b;
    modport master (
        output start, challenge_a, challenge_b, window_len, tie_thresh,
        input  busy, done, response, unstable, last_cnt_a, last_cnt_b
    );
    modport slave (
        input  start, challenge_a, challenge_b, window_len, tie_thresh,
        output busy, done, response, unstable, last_cnt_a, last_cnt_b
    );
endinterface

// File: rtl/ro_puf_sequencer_edge_counter.sv
// ro_puf_sequencer_edge_counter: synchronises one RO, detects rising edges and counts them with saturation
module ro_puf_sequencer_edge_counter
    import ro_puf_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    logic [SYNC_STAGES:0] sh_q, sh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rise;
    // top stage of the shift chain is the edge-detect history bit
    always_comb begin
        sh_d  = {sh_q[SYNC_STAGES-1:0], ro};
        rise  = sh_q[SYNC_STAGES-1] & ~sh_q[SYNC_STAGES];
        cnt_d = clr ? '0 : (en && rise && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/ro_puf_sequencer.sv
// ro_puf_sequencer: steps through RESP_BITS RO pairs, counts both ROs over a clk window and
// turns each count comparison into a response bit plus a tie flag
module ro_puf_sequencer
    import ro_puf_sequencer_pkg::*;
#(
    parameter int NUM_RO        = 16,
    parameter int SEL_W         = $clog2(NUM_RO),
    parameter int CNT_W         = 16,
    parameter int WIN_W         = 16,
    parameter int RESP_BITS     = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_RO-1:0] ro_in,
    output logic              ro_en,
    ro_puf_sequencer_if.slave bus
);
    localparam int KW = RESP_BITS > 1 ? $clog2(RESP_BITS) : 1;
    localparam logic [WIN_W-1:0] SET_LD = WIN_W'(SETTLE_CYCLES - 1);

    state_t               state_q, state_d;
    logic [WIN_W-1:0]     tmr_q, tmr_d, wlen_q, wlen_d;
    logic [KW-1:0]        k_q, k_d;
    logic [SEL_W-1:0]     a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]     thr_q, thr_d, lca_q, lca_d, lcb_q, lcb_d;
    logic [CNT_W-1:0]     cnt_a, cnt_b, diff;
    logic [RESP_BITS-1:0] resp_q, resp_d, unst_q, unst_d;
    logic                 tmr_zero, last_bit, cnt_clr, cnt_en, gt, tie;

    assign tmr_zero = tmr_q == '0;
    assign last_bit = k_q == KW'(RESP_BITS - 1);
    assign diff     = cnt_a > cnt_b ? cnt_a - cnt_b : cnt_b - cnt_a;
    assign gt       = a_q != b_q && cnt_a > cnt_b;
    assign tie      = a_q == b_q || diff <= thr_q;

    // raw RO outputs are muxed first; the settle period absorbs the switch glitch and sync latency
    ro_puf_sequencer_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk(clk), .rst_n(rst_n), .ro(ro_in[a_q]), .clr(cnt_clr), .en(cnt_en), .cnt(cnt_a)
    );
    ro_puf_sequencer_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk(clk), .rst_n(rst_n), .ro(ro_in[b_q]), .clr(cnt_clr), .en(cnt_en), .cnt(cnt_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? SETTLE : IDLE;
            SETTLE:  state_d = tmr_zero ? COUNT : SETTLE;
            COUNT:   state_d = tmr_zero ? COMPARE : COUNT;
            COMPARE: state_d = last_bit ? DONE : SETTLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = state_q == SETTLE;
        cnt_en   = state_q == COUNT;
        ro_en    = state_q == SETTLE || state_q == COUNT || state_q == COMPARE;
        bus.busy = state_q == SETTLE || state_q == COUNT || state_q == COMPARE;
        bus.done = state_q == DONE;
    end

    always_comb begin
        tmr_d  = tmr_q;
        wlen_d = wlen_q;
        k_d    = k_q;
        a_d    = a_q;
        b_d    = b_q;
        thr_d  = thr_q;
        lca_d  = lca_q;
        lcb_d  = lcb_q;
        resp_d = resp_q;
        unst_d = unst_q;
        case (state_q)
            IDLE: if (bus.start) begin
                a_d    = SEL_W'(32'(bus.challenge_a) % NUM_RO);
                b_d    = SEL_W'(32'(bus.challenge_b) % NUM_RO);
                wlen_d = bus.window_len == '0 ? WIN_W'(1) : bus.window_len;
                thr_d  = bus.tie_thresh;
                resp_d = '0;
                unst_d = '0;
                k_d    = '0;
                tmr_d  = SET_LD;
            end
            SETTLE:  tmr_d = tmr_zero ? wlen_q - WIN_W'(1) : tmr_q - WIN_W'(1);
            COUNT:   tmr_d = tmr_q - WIN_W'(1);
            COMPARE: begin
                resp_d = resp_q | (RESP_BITS'(gt) << k_q);
                unst_d = unst_q | (RESP_BITS'(tie) << k_q);
                lca_d  = cnt_a;
                lcb_d  = cnt_b;
                k_d    = k_q + KW'(1);
                a_d    = a_q == SEL_W'(NUM_RO - 1) ? '0 : a_q + SEL_W'(1);
                b_d    = b_q == SEL_W'(NUM_RO - 1) ? '0 : b_q + SEL_W'(1);
                tmr_d  = SET_LD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q  <= '0;
            wlen_q <= '0;
            k_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            thr_q  <= '0;
            lca_q  <= '0;
            lcb_q  <= '0;
            resp_q <= '0;
            unst_q <= '0;
        end else begin
            tmr_q  <= tmr_d;
            wlen_q <= wlen_d;
            k_q    <= k_d;
            a_q    <= a_d;
            b_q    <= b_d;
            thr_q  <= thr_d;
            lca_q  <= lca_d;
            lcb_q  <= lcb_d;
            resp_q <= resp_d;
            unst_q <= unst_d;
        end
    end

    assign bus.response   = resp_q;
    assign bus.unstable   = unst_q;
    assign bus.last_cnt_a = lca_q;
    assign bus.last_cnt_b = lcb_q;
endmodule

// File: tb/tb_ro_puf_sequencer.sv
// tb_ro_puf_sequencer: three sequencer variants driven by square-wave ROs and checked against a window edge-count model
module tb_ro_puf_sequencer;
  localparam int S = 4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ro_in = '0;
  logic        ro_en8, ro_en1, ro_ens;
  logic        start;
  logic [3:0]  ca, cb;
  logic [15:0] wl, th;
  int          cyc = 0;
  int          per[16], ph[16];
  int          nd8 = 0, nd1 = 0, nds = 0;
  int          c0, cy8, cy1, cys;
  int          ncmp = 0, nfail = 0;

  ro_puf_sequencer_if #(.SEL_W(4), .CNT_W(16), .WIN_W(16), .RESP_BITS(8)) bus8 ();
  ro_puf_sequencer_if #(.SEL_W(4), .CNT_W(16), .WIN_W(16), .RESP_BITS(1)) bus1 ();
  ro_puf_sequencer_if #(.SEL_W(4), .CNT_W(4),  .WIN_W(16), .RESP_BITS(1)) buss ();

  assign bus8.start = start; assign bus8.challenge_a = ca; assign bus8.challenge_b = cb;
  assign bus8.window_len = wl; assign bus8.tie_thresh = th;
  assign bus1.start = start; assign bus1.challenge_a = ca; assign bus1.challenge_b = cb;
  assign bus1.window_len = wl; assign bus1.tie_thresh = th;
  assign buss.start = start; assign buss.challenge_a = ca; assign buss.challenge_b = cb;
  assign buss.window_len = wl; assign buss.tie_thresh = th[3:0];

  ro_puf_sequencer #(.RESP_BITS(8)) u8 (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(ro_en8), .bus(bus8.slave));
  ro_puf_sequencer #(.RESP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(ro_en1), .bus(bus1.slave));
  ro_puf_sequencer #(.CNT_W(4), .RESP_BITS(1)) us (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(ro_ens), .bus(buss.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string t, input logic [127:0] o, input logic [127:0] e);
    ncmp++;
    if (o !== e) begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask

  function automatic logic wave(int i, int n);
    return n < 0 ? 1'b0 : 1'(((n + ph[i]) / (per[i] / 2)) % 2);
  endfunction

  function automatic int edges(int i, int base, int w);
    int n = 0;
    for (int m = base; m < base + w; m++) n += int'(wave(i, m - 3) && !wave(i, m - 4));
    return n;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 16; i++) ro_in[i] = wave(i, cyc);
    if (bus8.done) nd8++;
    if (bus1.done) nd1++;
    if (buss.done) nds++;
  end

  task automatic model(input int a0, b0, w, t, r, cw,
                       output logic [7:0] rs, us_, output int la, lb);
    int mx;
    mx = (1 << cw) - 1;
    rs = '0;
    us_ = '0;
    la = 0;
    lb = 0;
    for (int k = 0; k < r; k++) begin
      int a, b, base;
      a = (a0 + k) % 16;
      b = (b0 + k) % 16;
      base = c0 + k * (S + w + 1) + S + 1;
      la = edges(a, base, w);
      lb = edges(b, base, w);
      if (la > mx) la = mx;
      if (lb > mx) lb = mx;
      rs[k] = a != b && la > lb;
      us_[k] = a == b || (la > lb ? la - lb : lb - la) <= (t & mx);
    end
  endtask

  task automatic run(input int a, b, w, t, input bit poke);
    logic [7:0] r8, u8_, r1, u1_, rs, us_;
    int la8, lb8, la1, lb1, las, lbs, s8, s1, ss, weff;
    repeat (2) @(negedge clk);
    ca = 4'(a); cb = 4'(b); wl = 16'(w); th = 16'(t);
    weff = w == 0 ? 1 : w;
    s8 = nd8; s1 = nd1; ss = nds;
    cy8 = -1; cy1 = -1; cys = -1;
    start = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {bus8.busy, bus1.busy, buss.busy, ro_en8}, 4'hf);
    chk("resp_cleared", bus8.response, 8'h0);
    model(a, b, weff, t, 8, 16, r8, u8_, la8, lb8);
    model(a, b, weff, t, 1, 16, r1, u1_, la1, lb1);
    model(a, b, weff, t, 1, 4, rs, us_, las, lbs);
    if (poke) begin
      repeat (20) @(negedge clk);
      start = 1'b1; ca = ~ca; cb = 4'(a); wl = 16'd1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 8 * (S + weff + 1) + 40 && (cy8 < 0 || cy1 < 0 || cys < 0); i++) begin
      @(negedge clk);
      if (bus8.done && cy8 < 0) cy8 = cyc;
      if (bus1.done && cy1 < 0) cy1 = cyc;
      if (buss.done && cys < 0) cys = cyc;
    end
    chk("done_seen", {cy8 >= 0, cy1 >= 0, cys >= 0}, 3'b111);
    repeat (3) @(negedge clk);
    chk("lat8", cy8 - c0 + 1, 8 * (S + weff + 1) + 1);
    chk("lat1", cy1 - c0 + 1, S + weff + 2);
    chk("lats", cys - c0 + 1, S + weff + 2);
    chk("one_done", {nd8 - s8, nd1 - s1, nds - ss}, {32'd1, 32'd1, 32'd1});
    chk("idle", {bus8.busy, bus1.busy, buss.busy, ro_en8, ro_en1, ro_ens}, 6'h0);
    chk("resp8", bus8.response, r8);
    chk("unst8", bus8.unstable, u8_);
    chk("cnt8", {bus8.last_cnt_a, bus8.last_cnt_b}, {16'(la8), 16'(lb8)});
    chk("resp1", {bus1.response, bus1.unstable}, {r1[0], u1_[0]});
    chk("cnt1", {bus1.last_cnt_a, bus1.last_cnt_b}, {16'(la1), 16'(lb1)});
    chk("resps", {buss.response, buss.unstable}, {rs[0], us_[0]});
    chk("cnts", {buss.last_cnt_a, buss.last_cnt_b}, {4'(las), 4'(lbs)});
  endtask

  task automatic shuffle_ros();
    for (int i = 0; i < 16; i++) begin
      per[i] = 2 * $urandom_range(2, 12);
      ph[i] = $urandom_range(0, per[i] - 1);
    end
  endtask

  initial begin
    int snap;
    rst_n = 1'b0; start = 1'b0; ca = '0; cb = '0; wl = '0; th = '0;
    for (int i = 0; i < 16; i++) begin
      per[i] = 8 + 2 * i;
      ph[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {bus8.busy, bus8.done, ro_en8, bus1.busy, bus1.done, buss.done}, 6'h0);
    chk("reset_data", {bus8.response, bus8.unstable, bus8.last_cnt_a, bus8.last_cnt_b}, 48'h0);
    rst_n = 1'b1;
    per[3] = 8; per[5] = 12;
    run(3, 5, 240, 2, 0);
    chk("dir_resp", {bus1.response, bus1.unstable}, 2'b10);
    chk("dir_cnt_a", bus1.last_cnt_a >= 16'd29 && bus1.last_cnt_a <= 16'd31, 1'b1);
    chk("dir_cnt_b", bus1.last_cnt_b >= 16'd19 && bus1.last_cnt_b <= 16'd21, 1'b1);
    chk("dir_lat246", cy1 - c0 + 1, 246);
    per[5] = 8;
    run(3, 5, 240, 2, 0);
    chk("equal_period_tie", bus1.unstable, 1'b1);
    run(7, 7, 240, 2, 0);
    chk("same_ro", {bus1.response, bus1.unstable}, 2'b01);
    per[0] = 4; per[1] = 8;
    run(0, 1, 200, 3, 0);
    chk("saturate", buss.last_cnt_a, 4'd15);
    run(4, 9, 0, 0, 0);
    chk("w0_lat", cy1 - c0 + 1, 7);
    shuffle_ros();
    run(15, 14, 50, 1, 0);
    run(6, 2, 100, 2, 1);
    per[3] = 8; per[5] = 12; ph[3] = 0; ph[5] = 0;
    run(3, 5, 60, 1, 0);
    repeat (2) @(negedge clk);
    snap = nd8;
    ca = 4'd3; cb = 4'd5; wl = 16'd60; th = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_ctrl", {bus8.busy, bus8.done, ro_en8, bus1.busy, ro_en1, buss.busy, ro_ens}, 7'h0);
    chk("rst_mid_data", {bus8.response, bus8.unstable, bus1.response, bus1.unstable, buss.response}, 19'h0);
    chk("rst_mid_cnt", {bus8.last_cnt_a, bus1.last_cnt_a, buss.last_cnt_a}, 36'h0);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    chk("rst_no_done", nd8 - snap, 0);
    run(3, 5, 60, 1, 0);
    for (int n = 0; n < 5; n++) begin
      shuffle_ros();
      run($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 60), $urandom_range(0, 4), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
